// File: rtl/csa9_operand_collector.sv
// Operand collector around the nine-operand carry-save adder tree: loads operands
// one per cycle into a register bank, then captures and offers the adder result.
module csa9_operand_collector #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_OPS = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic [NUM_OPS*WIDTH-1:0]   ops_flat,
   input  logic [19:0]                add_sum,
   input  logic                       add_cout,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [20:0]                res_data,
   output logic [3:0]                 count,
   output logic                       err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned RES_W = 21;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_release;
   logic                 r_in_ready;
   logic                 r_res_valid;
   logic [CNT_W-1:0]     r_count;
   logic [RES_W-1:0]     r_res;
   logic                 r_err;
   logic [WIDTH-1:0]     r_slot [NUM_OPS];

   // State register; rst and clear both return to LOAD.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode; clear suppresses every handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         LOAD: begin
            if (in_valid) begin
               w_accept = 1'b1;
               if (r_count == CNT_W'(NUM_OPS - 1)) begin
                  w_state_nxt = EVAL;
               end
            end
         end
         EVAL: begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               w_release   = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         default: begin
            w_state_nxt = LOAD;
         end
      endcase
      if (rst || clear) begin
         w_state_nxt = LOAD;
         w_accept    = 1'b0;
         w_capture   = 1'b0;
         w_release   = 1'b0;
      end
   end

   // Handshake flags are registered copies of the next-state decode.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_in_ready  <= 1'b1;
         r_res_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == LOAD);
         r_res_valid <= (w_state_nxt == HOLD);
      end
   end

   // Operand bank, batch counter and result register.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
         r_res   <= '0;
         for (int k = 0; k < int'(NUM_OPS); k++) begin
            r_slot[k] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            for (int k = 0; k < int'(NUM_OPS); k++) begin
               if (r_count == CNT_W'(k)) begin
                  r_slot[k] <= in_data;
               end
            end
         end else if (w_release) begin
            r_count <= '0;
         end
         if (w_capture) begin
            r_res <= {add_cout, add_sum};
         end
      end
   end

   // Sticky adder-fault flag; clear leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_capture && add_cout) begin
         r_err <= 1'b1;
      end
   end

   for (genvar k = 0; k < int'(NUM_OPS); k++) begin : g_flat
      assign ops_flat[k*WIDTH +: WIDTH] = r_slot[k];
   end

   assign in_ready  = r_in_ready;
   assign res_valid = r_res_valid;
   assign res_data  = r_res;
   assign count     = r_count;
   assign err       = r_err;

endmodule

// File: tb/tb_csa9_operand_collector.sv
// Directed bench for csa9_operand_collector with a behavioural nine-input adder.
module tb_csa9_operand_collector;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic [143:0]  ops_flat;
   logic [19:0]   add_sum;
   logic          add_cout;
   logic          res_valid;
   logic          res_ready;
   logic [20:0]   res_data;
   logic [3:0]    count;
   logic          err;
   logic          force_cout;

   int errors = 0;
   int checks = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   csa9_operand_collector #(.WIDTH(16), .NUM_OPS(9)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ops_flat(ops_flat), .add_sum(add_sum), .add_cout(add_cout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .count(count), .err(err)
   );

   // Stand-in adder tree.
   always_comb begin
      add_sum = '0;
      for (int k = 0; k < 9; k++) add_sum = add_sum + 20'(ops_flat[k*16 +: 16]);
      add_cout = force_cout;
   end

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [8:0][15:0] ops;
      logic [20:0]      exp;
      bit               gaps;
      int               hold;
   } vec_t;

   vec_t vecs [5];

   // Loads nine words, checks EVAL and HOLD, optionally releases the result.
   task automatic run_batch(input logic [8:0][15:0] ops, input logic [20:0] exp,
                            input bit gaps, input int hold, input bit release_res);
      for (int i = 0; i < 9; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               chk("gap_count", 144'(count), 144'(i));
            end
         end
         chk("load_in_ready", 144'(in_ready), 144'(1));
         in_valid = 1'b1;
         in_data  = ops[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 16'h0;
      chk("eval_in_ready", 144'(in_ready), 144'(0));
      chk("eval_res_valid", 144'(res_valid), 144'(0));
      chk("eval_count", 144'(count), 144'(9));
      chk("eval_ops_flat", ops_flat, ops);
      @(negedge clk);
      if (force_cout) exp_err = 1'b1;
      chk("hold_res_valid", 144'(res_valid), 144'(1));
      chk("hold_res_data", 144'(res_data), 144'(exp));
      chk("hold_err", 144'(err), 144'(exp_err));
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         chk("stall_res_valid", 144'(res_valid), 144'(1));
         chk("stall_in_ready", 144'(in_ready), 144'(0));
         chk("stall_res_data", 144'(res_data), 144'(exp));
      end
      if (release_res) begin
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         chk("rel_res_valid", 144'(res_valid), 144'(0));
         chk("rel_in_ready", 144'(in_ready), 144'(1));
         chk("rel_count", 144'(count), 144'(0));
      end
   endtask

   logic [8:0][15:0] w_ops;

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      res_ready = 1'b0; force_cout = 1'b0;

      for (int k = 0; k < 9; k++) begin
         vecs[0].ops[k] = 16'(k + 1);
         vecs[1].ops[k] = 16'hFFFF;
         vecs[2].ops[k] = 16'h0000;
         vecs[4].ops[k] = 16'hABCD;
      end
      vecs[0].exp = 21'h0002D; vecs[0].gaps = 1'b0; vecs[0].hold = 0;
      vecs[1].exp = 21'h8FFF7; vecs[1].gaps = 1'b0; vecs[1].hold = 0;
      vecs[2].exp = 21'h00000; vecs[2].gaps = 1'b0; vecs[2].hold = 0;
      vecs[3].ops[0] = 16'h0001; vecs[3].ops[1] = 16'h0010; vecs[3].ops[2] = 16'h0100;
      vecs[3].ops[3] = 16'h1000; vecs[3].ops[4] = 16'h8000; vecs[3].ops[5] = 16'h8000;
      vecs[3].ops[6] = 16'h0000; vecs[3].ops[7] = 16'h7FFF; vecs[3].ops[8] = 16'h0001;
      vecs[3].exp = 21'h19111; vecs[3].gaps = 1'b1; vecs[3].hold = 5;
      vecs[4].exp = 21'h60A35; vecs[4].gaps = 1'b1; vecs[4].hold = 2;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", 144'(in_ready), 144'(1));
      chk("rst_res_valid", 144'(res_valid), 144'(0));
      chk("rst_res_data", 144'(res_data), 144'(0));
      chk("rst_count", 144'(count), 144'(0));
      chk("rst_err", 144'(err), 144'(0));
      chk("rst_ops_flat", ops_flat, 144'(0));

      for (int v = 0; v < 5; v++)
         run_batch(vecs[v].ops, vecs[v].exp, vecs[v].gaps, vecs[v].hold, 1'b1);

      // clear after five words; a word presented with clear is dropped
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'h0010;
         @(negedge clk);
      end
      chk("pre_clear_count", 144'(count), 144'(5));
      clear = 1'b1; in_data = 16'hFFFF;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      chk("clear_count", 144'(count), 144'(0));
      chk("clear_in_ready", 144'(in_ready), 144'(1));
      chk("clear_res_valid", 144'(res_valid), 144'(0));
      chk("clear_ops_flat", ops_flat, 144'(0));
      for (int k = 0; k < 9; k++) w_ops[k] = 16'h0001;
      run_batch(w_ops, 21'h00009, 1'b0, 0, 1'b1);

      // adder fault: carry-out captured, err sticky through clear and a clean batch
      force_cout = 1'b1;
      run_batch(w_ops, 21'h100009, 1'b0, 0, 1'b0);
      force_cout = 1'b0;
      chk("fault_res_bit20", 144'(res_data[20]), 144'(1));
      chk("fault_err", 144'(err), 144'(1));
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_keeps_err", 144'(err), 144'(1));
      chk("clear_res_data", 144'(res_data), 144'(0));
      run_batch(vecs[0].ops, 21'h0002D, 1'b0, 1, 1'b0);

      // rst in HOLD drops the result and err
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_err = 1'b0;
      chk("hold_rst_res_valid", 144'(res_valid), 144'(0));
      chk("hold_rst_res_data", 144'(res_data), 144'(0));
      chk("hold_rst_count", 144'(count), 144'(0));
      chk("hold_rst_in_ready", 144'(in_ready), 144'(1));
      chk("hold_rst_err", 144'(err), 144'(0));

      run_batch(vecs[3].ops, vecs[3].exp, 1'b0, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
